router_input_ctrl: RTL and testbench

Input-side controller for one router port in the ring network: buffers incoming messages in a small FIFO, computes the output route of the head message from its destination field, raises a one-hot request toward the output-port arbiters, and dequeues the head when a matching grant returns. It is the counterpart of the per-output arbitration control: its `reqs` feed the arbiters' request inputs, and it consumes their `grants`. Its `out_msg` drives the crossbar data input for this port.

---
 rtl/router_input_ctrl.sv | 97 +++++++++
 tb/tb_router_input_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/router_input_ctrl.sv
// Input-port controller for a ring router. It buffers arriving messages in a circular FIFO,
// routes the head message toward west, terminal or east, and dequeues the head on a matching grant.
module router_input_ctrl #(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 4,
  parameter int p_msg_nbits   = 44,
  parameter int p_dest_nbits  = 2,
  parameter int p_num_entries = 4
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     in_val_i,
  output logic                                     in_rdy_o,
  input  logic [p_msg_nbits-1:0]                   in_msg_i,
  output logic [2:0]                               reqs_o,
  input  logic [2:0]                               grants_i,
  output logic [p_msg_nbits-1:0]                   out_msg_o,
  output logic [$clog2(p_num_entries+1)-1:0]       count_o
);

  localparam int          CW     = $clog2(p_num_entries + 1);
  localparam int          PW     = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam logic [31:0] N      = 32'(p_num_routers);
  localparam logic [31:0] ID     = 32'(p_router_id);
  localparam logic [31:0] ID_MOD = ID % N;
  localparam logic [31:0] HALF   = N / 32'd2;
  localparam logic [PW-1:0] LAST = PW'(p_num_entries - 1);
  localparam logic [CW-1:0] FULL = CW'(p_num_entries);

  logic [p_msg_nbits-1:0]  mem_q [p_num_entries];
  logic [PW-1:0]           head_q, head_d;
  logic [PW-1:0]           tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    enq, deq;
  logic [p_dest_nbits-1:0] head_dest;
  logic [31:0]             dest_ext;
  logic [31:0]             fwd_dist;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST) ? '0 : ptr + PW'(1);
  endfunction

  // Route depends only on registered state, so grants never loop back into reqs.
  always_comb begin
    head_dest = mem_q[head_q][p_msg_nbits-1 -: p_dest_nbits];
    dest_ext  = 32'(head_dest);
    fwd_dist  = ((dest_ext % N) + N - ID_MOD) % N;
    reqs_o    = 3'b000;
    if (count_q != '0) begin
      if (dest_ext == ID)
        reqs_o = 3'b010;
      else if (fwd_dist <= HALF)
        reqs_o = 3'b100;
      else
        reqs_o = 3'b001;
    end
  end

  always_comb begin
    in_rdy_o  = (count_q != FULL);
    out_msg_o = mem_q[head_q];
    count_o   = count_q;
    enq       = in_val_i && in_rdy_o;
    deq       = (count_q != '0) && ((grants_i & reqs_o) != 3'b000);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) tail_d = next_ptr(tail_q);
    if (deq) head_d = next_ptr(head_q);
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is intentionally left unreset; count gates its validity.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[tail_q] <= in_msg_i;
  end

endmodule

// File: tb/tb_router_input_ctrl.sv
// Directed bench for router_input_ctrl at router id 1 in a 4-router ring.
// Routing is table-driven; full, stall, streaming, empty-grant and async reset are hand sequences.
module tb_router_input_ctrl;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [43:0] in_msg;
  logic [2:0]  reqs;
  logic [2:0]  grants;
  logic [43:0] out_msg;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  router_input_ctrl #(
    .p_router_id  (1),
    .p_num_routers(4),
    .p_msg_nbits  (44),
    .p_dest_nbits (2),
    .p_num_entries(4)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .in_val_i (in_val),
    .in_rdy_o (in_rdy),
    .in_msg_i (in_msg),
    .reqs_o   (reqs),
    .grants_i (grants),
    .out_msg_o(out_msg),
    .count_o  (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  dest;
    logic [41:0] payload;
    logic [2:0]  exp_reqs;
  } vec_t;

  vec_t        vecs[4];
  logic [2:0]  route_lut[4];
  logic [43:0] full_msgs[4];
  logic [43:0] stream_msgs[10];
  logic [43:0] held_msg;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [43:0] mk(input logic [1:0] d, input logic [41:0] p);
    return {d, p};
  endfunction

  initial begin
    // id = 1, N = 4: fd = (D - 1) mod 4, tie at fd = 2 goes east
    vecs[0] = '{dest: 2'd1, payload: 42'h0_1111_1111, exp_reqs: 3'b010};
    vecs[1] = '{dest: 2'd2, payload: 42'h2_2222_2222, exp_reqs: 3'b100};
    vecs[2] = '{dest: 2'd3, payload: 42'h3_3333_3333, exp_reqs: 3'b100};
    vecs[3] = '{dest: 2'd0, payload: 42'h0_4444_4444, exp_reqs: 3'b001};
    route_lut[0] = 3'b001;
    route_lut[1] = 3'b010;
    route_lut[2] = 3'b100;
    route_lut[3] = 3'b100;

    reset  = 1'b1;
    in_val = 1'b0;
    in_msg = '0;
    grants = 3'b000;
    #1;
    check("reset_count", 64'(count), 64'd0);
    check("reset_in_rdy", 64'(in_rdy), 64'd1);
    check("reset_reqs", 64'(reqs), 64'd0);
    tick();
    tick();
    #3 reset = 1'b0;

    // Routing table
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1;
      in_msg = mk(vecs[i].dest, vecs[i].payload);
      tick();
      in_val = 1'b0;
      check($sformatf("route%0d_reqs", i), 64'(reqs), 64'(vecs[i].exp_reqs));
      check($sformatf("route%0d_msg", i), 64'(out_msg), 64'(mk(vecs[i].dest, vecs[i].payload)));
      check($sformatf("route%0d_count", i), 64'(count), 64'd1);
      grants = vecs[i].exp_reqs;
      tick();
      grants = 3'b000;
      check($sformatf("route%0d_drain", i), 64'(count), 64'd0);
      check($sformatf("route%0d_reqs_empty", i), 64'(reqs), 64'd0);
    end

    // Full FIFO: fifth message refused even while a dequeue happens
    for (int i = 0; i < 4; i++) full_msgs[i] = mk(2'(i + 2), 42'(32'hA000 + i));
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1;
      in_msg = full_msgs[i];
      tick();
    end
    check("full_count", 64'(count), 64'd4);
    check("full_in_rdy", 64'(in_rdy), 64'd0);
    check("full_head_reqs", 64'(reqs), 64'(3'b100));
    in_msg = mk(2'd1, 42'hBAD);
    grants = 3'b100;
    tick();
    in_val = 1'b0;
    grants = 3'b000;
    check("full_after_count", 64'(count), 64'd3);
    check("full_after_in_rdy", 64'(in_rdy), 64'd1);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("full_drain%0d_msg", i), 64'(out_msg), 64'(full_msgs[i]));
      check($sformatf("full_drain%0d_reqs", i), 64'(reqs), 64'(route_lut[(i + 2) % 4]));
      grants = route_lut[(i + 2) % 4];
      tick();
      grants = 3'b000;
    end
    check("full_drained_count", 64'(count), 64'd0);

    // Stalled head: a non-matching grant must not dequeue
    held_msg = mk(2'd2, 42'h1_5555_AAAA);
    in_val = 1'b1;
    in_msg = held_msg;
    tick();
    in_val = 1'b0;
    grants = 3'b001;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall%0d_count", c), 64'(count), 64'd1);
      check($sformatf("stall%0d_reqs", c), 64'(reqs), 64'(3'b100));
      check($sformatf("stall%0d_msg", c), 64'(out_msg), 64'(held_msg));
    end
    grants = 3'b100;
    tick();
    grants = 3'b000;
    check("stall_release_count", 64'(count), 64'd0);

    // Streaming with simultaneous enqueue/dequeue; pointers wrap several times
    for (int i = 0; i < 10; i++) stream_msgs[i] = mk(2'(i % 4), 42'(32'hC000 + i * 7));
    in_val = 1'b1;
    in_msg = stream_msgs[0];
    tick();
    for (int i = 1; i <= 10; i++) begin
      check($sformatf("stream%0d_count", i), 64'(count), 64'd1);
      check($sformatf("stream%0d_msg", i), 64'(out_msg), 64'(stream_msgs[i - 1]));
      check($sformatf("stream%0d_reqs", i), 64'(reqs), 64'(route_lut[(i - 1) % 4]));
      if (i < 10) in_msg = stream_msgs[i];
      else        in_val = 1'b0;
      grants = route_lut[(i - 1) % 4];
      tick();
    end
    grants = 3'b000;
    check("stream_end_count", 64'(count), 64'd0);

    // Grant while empty is ignored; a following message must still appear at head
    grants = 3'b111;
    tick();
    tick();
    check("empty_grant_count", 64'(count), 64'd0);
    check("empty_grant_reqs", 64'(reqs), 64'd0);
    grants = 3'b000;
    held_msg = mk(2'd3, 42'h2_7777_0001);
    in_val = 1'b1;
    in_msg = held_msg;
    tick();
    check("empty_grant_after_msg", 64'(out_msg), 64'(held_msg));
    check("empty_grant_after_count", 64'(count), 64'd1);

    // Async reset mid-cycle with two entries buffered
    in_msg = mk(2'd0, 42'h3_0000_0002);
    tick();
    in_val = 1'b0;
    check("pre_reset_count", 64'(count), 64'd2);
    #2 reset = 1'b1;
    #1;
    check("async_reset_count", 64'(count), 64'd0);
    check("async_reset_in_rdy", 64'(in_rdy), 64'd1);
    check("async_reset_reqs", 64'(reqs), 64'd0);
    #2 reset = 1'b0;
    held_msg = mk(2'd1, 42'h0_0BEE_F000);
    in_val = 1'b1;
    in_msg = held_msg;
    tick();
    in_val = 1'b0;
    check("post_reset_reqs", 64'(reqs), 64'(3'b010));
    check("post_reset_count", 64'(count), 64'd1);
    check("post_reset_msg", 64'(out_msg), 64'(held_msg));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
